soc_system_status_in: RTL



---
 rtl/soc_system_pio_pkg.sv | 34 +++
 rtl/soc_system_status_in_if.sv | 33 +++
 rtl/soc_system_bit_sync.sv | 27 ++
 rtl/soc_system_status_in.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/soc_system_pio_pkg.sv
// Shared definitions for the soc_system PIO blocks on the lightweight HPS-to-FPGA bridge.
// Holds the register map, the edge-select encodings and the Avalon data width.
package soc_system_pio_pkg;

    // Avalon data bus width; also the upper bound on the number of status lines
    localparam int unsigned PIO_DATA_W = 32;

    // Word addresses of the status-input register map
    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_RSVD    = 2'd1;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

    // Edge-select encodings for the capture logic
    localparam int unsigned EDGE_RISING  = 0;
    localparam int unsigned EDGE_FALLING = 1;
    localparam int unsigned EDGE_ANY     = 2;

    // Edge-detect helper shared by any PIO that captures edges
    function automatic logic [PIO_DATA_W-1:0] pio_edge(
        input logic [PIO_DATA_W-1:0] cur,
        input logic [PIO_DATA_W-1:0] prev,
        input int unsigned           edge_type
    );
        logic [PIO_DATA_W-1:0] res;
        case (edge_type)
            EDGE_FALLING: res = ~cur & prev;
            EDGE_ANY:     res = cur ^ prev;
            default:      res = cur & ~prev;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/soc_system_status_in_if.sv
// Avalon-MM slave bus bundle for the status-input PIO: word address, select,
// active-low write strobe, write/read data and the level interrupt.
interface soc_system_status_in_if;
    import soc_system_pio_pkg::*;

    logic [1:0]            address;
    logic                  chipselect;
    logic                  write_n;
    logic [PIO_DATA_W-1:0] writedata;
    logic [PIO_DATA_W-1:0] readdata;
    logic                  irq;

    // HPS bridge side
    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata,
        input  irq
    );

    // PIO side
    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata,
        output irq
    );

endinterface

// File: rtl/soc_system_bit_sync.sv
// Multi-bit, multi-stage synchronizer for independent asynchronous status lines.
// Each bit is synchronized on its own; no coherency between bits is implied.
module soc_system_bit_sync #(
    parameter int unsigned WIDTH       = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    // Stage 0 is the metastability-catching flop; the last stage is the output
    logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync;

    // Shift the asynchronous inputs through the flop chain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/soc_system_status_in.sv
// Avalon-MM status-input PIO: synchronizes WIDTH asynchronous status flags from the
// audio/karaoke fabric, captures selected edges in a sticky W1C register and drives a
// maskable level interrupt to the HPS. Read latency is fixed at one cycle.
module soc_system_status_in
    import soc_system_pio_pkg::*;
#(
    parameter int unsigned           WIDTH       = 4,
    parameter int unsigned           SYNC_STAGES = 2,
    parameter int unsigned           EDGE_TYPE   = EDGE_RISING,
    parameter logic [PIO_DATA_W-1:0] RESET_MASK  = '0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     in_port,
    soc_system_status_in_if.slave bus
);

    // Arming holds off capture until the synchronizer and prev register have been
    // filled with post-reset samples, so lines already high at release do not fire.
    localparam int unsigned ARM_MAX   = SYNC_STAGES + 1;
    localparam logic [2:0]  ARM_MAX_C = 3'(ARM_MAX);

    logic [WIDTH-1:0]      w_data;
    logic [WIDTH-1:0]      r_prev;
    logic [WIDTH-1:0]      w_edge;
    logic [WIDTH-1:0]      r_edge_cap;
    logic [WIDTH-1:0]      w_edge_cap_d;
    logic [WIDTH-1:0]      w_clear;
    logic [WIDTH-1:0]      r_irq_mask;
    logic [2:0]            r_arm_cnt;
    logic                  w_armed;
    logic                  w_wr;
    logic                  w_wr_mask;
    logic                  w_wr_ecap;
    logic [PIO_DATA_W-1:0] w_rdata;
    logic [PIO_DATA_W-1:0] r_readdata;

    soc_system_bit_sync #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (reset),
        .i_d (in_port),
        .o_q (w_data)
    );

    // Write decode; the slave never stalls
    assign w_wr      = bus.chipselect && !bus.write_n;
    assign w_wr_mask = w_wr && (bus.address == ADDR_IRQMASK);
    assign w_wr_ecap = w_wr && (bus.address == ADDR_EDGECAP);
    assign w_armed   = (r_arm_cnt == ARM_MAX_C);

    // Count post-reset cycles and saturate once armed
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_arm_cnt <= '0;
        end else if (!w_armed) begin
            r_arm_cnt <= r_arm_cnt + 3'd1;
        end
    end

    // Keep the previous synchronized value for edge detection
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prev <= '0;
        end else begin
            r_prev <= w_data;
        end
    end

    // Select the configured edge from current and previous synchronized values
    always_comb begin
        w_edge = '0;
        if (EDGE_TYPE == EDGE_FALLING) begin
            w_edge = ~w_data & r_prev;
        end else if (EDGE_TYPE == EDGE_ANY) begin
            w_edge = w_data ^ r_prev;
        end else begin
            w_edge = w_data & ~r_prev;
        end
    end

    // Sticky capture with write-1-to-clear; a new edge beats a same-cycle clear
    always_comb begin
        w_clear      = '0;
        if (w_wr_ecap) begin
            w_clear = bus.writedata[WIDTH-1:0];
        end
        w_edge_cap_d = (r_edge_cap & ~w_clear) | ({WIDTH{w_armed}} & w_edge);
    end

    // Edge capture register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_edge_cap <= '0;
        end else begin
            r_edge_cap <= w_edge_cap_d;
        end
    end

    // Interrupt mask register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_irq_mask <= RESET_MASK[WIDTH-1:0];
        end else if (w_wr_mask) begin
            r_irq_mask <= bus.writedata[WIDTH-1:0];
        end
    end

    // Read mux of the current address; upper bits stay zero
    always_comb begin
        w_rdata = '0;
        case (bus.address)
            ADDR_DATA:    w_rdata[WIDTH-1:0] = w_data;
            ADDR_IRQMASK: w_rdata[WIDTH-1:0] = r_irq_mask;
            ADDR_EDGECAP: w_rdata[WIDTH-1:0] = r_edge_cap;
            default:      w_rdata = '0;
        endcase
    end

    // Register read data every cycle for a fixed one-cycle read latency
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_readdata <= '0;
        end else begin
            r_readdata <= w_rdata;
        end
    end

    assign bus.readdata = r_readdata;
    assign bus.irq      = |(r_edge_cap & r_irq_mask);

    // Write data above WIDTH has no destination
    if (WIDTH < PIO_DATA_W) begin : g_unused_wdata
        logic w_unused_wdata;
        assign w_unused_wdata = ^bus.writedata[PIO_DATA_W-1:WIDTH];
    end

endmodule
